id_ex_skid_reg: RTL and testbench

- Parametrised successor to the ID/EX pipeline register for the MIPS_Cpu pipeline.
- Captures the decoded instruction bundle from ID.
- Adds a valid/ready handshake with a one-entry skid buffer, so EX back-pressure never drops an instruction.
- Adds synchronous flush (bubble insertion), a load-use hazard flag for the hazard unit, and a saturating stall counter for performance debug.

---
 rtl/id_ex_skid_reg.sv | 203 ++++++++++++++++++++
 tb/tb_id_ex_skid_reg.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_skid_reg.sv
// ---------------------------------------------------------------------------
// id_ex_skid_reg
//
// ID/EX pipeline register with a valid/ready handshake and a one-entry skid
// buffer. When EX back-pressures, one extra bundle is parked in SKID, so no
// instruction is ever dropped. The block also provides:
//   - synchronous flush, which turns the stage into a bubble
//   - a combinational load-use hazard flag for the hazard unit
//   - a saturating counter of back-pressure cycles, for performance debug
//
// Ports:
//   clk, rst            clock; synchronous active-high reset
//   i_valid / o_ready   upstream handshake (o_ready is registered: skid empty)
//   i_flush             discard held and incoming instructions this cycle
//   i_rs..i_operation   decoded instruction bundle from ID
//   o_valid / i_ready   downstream handshake
//   o_rs..o_operation   registered bundle presented to EX
//   o_dst               registered destination register (rt for addi/lw, else rd)
//   o_load_use          load in EX-stage register matches a source of ID bundle
//   o_stall_cnt         saturating count of cycles with i_valid && !o_ready
// ---------------------------------------------------------------------------
module id_ex_skid_reg #(
  parameter int unsigned   DATA_W      = 32,
  parameter int unsigned   REG_W       = 5,
  parameter int unsigned   OP_W        = 6,
  parameter logic [OP_W-1:0] NOP_OP    = 6'b111111,
  parameter logic [OP_W-1:0] ADDI_OP   = 6'b001000,
  parameter logic [OP_W-1:0] LW_OP     = 6'b100011,
  parameter int unsigned   STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  // Upstream (ID) side
  input  logic                   i_valid,
  output logic                   o_ready,
  input  logic                   i_flush,
  input  logic [REG_W-1:0]       i_rs,
  input  logic [REG_W-1:0]       i_rt,
  input  logic [REG_W-1:0]       i_rd,
  input  logic [REG_W-1:0]       i_res,
  input  logic [1:0]             i_ex,
  input  logic [2:0]             i_m,
  input  logic [1:0]             i_wb,
  input  logic [DATA_W-1:0]      i_valA,
  input  logic [DATA_W-1:0]      i_valB,
  input  logic [DATA_W-1:0]      i_imm,
  input  logic [DATA_W-1:0]      i_pc_plus4,
  input  logic [OP_W-1:0]        i_operation,
  // Downstream (EX) side
  output logic                   o_valid,
  input  logic                   i_ready,
  output logic [REG_W-1:0]       o_rs,
  output logic [REG_W-1:0]       o_rt,
  output logic [REG_W-1:0]       o_rd,
  output logic [REG_W-1:0]       o_res,
  output logic [1:0]             o_ex,
  output logic [2:0]             o_m,
  output logic [1:0]             o_wb,
  output logic [DATA_W-1:0]      o_valA,
  output logic [DATA_W-1:0]      o_valB,
  output logic [DATA_W-1:0]      o_imm,
  output logic [DATA_W-1:0]      o_pc_plus4,
  output logic [OP_W-1:0]        o_operation,
  output logic [REG_W-1:0]       o_dst,
  // Hazard / debug
  output logic                   o_load_use,
  output logic [STALL_CNT_W-1:0] o_stall_cnt
);

  typedef struct packed {
    logic [REG_W-1:0]  rs;
    logic [REG_W-1:0]  rt;
    logic [REG_W-1:0]  rd;
    logic [REG_W-1:0]  res;
    logic [REG_W-1:0]  dst;
    logic [1:0]        ex;
    logic [2:0]        m;
    logic [1:0]        wb;
    logic [DATA_W-1:0] val_a;
    logic [DATA_W-1:0] val_b;
    logic [DATA_W-1:0] imm;
    logic [DATA_W-1:0] pc_plus4;
    logic [OP_W-1:0]   operation;
  } bundle_t;

  bundle_t                out_q, out_d;
  bundle_t                skid_q, skid_d;
  bundle_t                in_bundle;
  bundle_t                bubble;
  logic                   out_valid_q, out_valid_d;
  logic                   skid_valid_q, skid_valid_d;
  logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic accept;
  logic drain;

  // Bubble: every field zero except the opcode, so EX sees a no-op even if it
  // ignores o_valid.
  always_comb begin
    bubble           = '0;
    bubble.operation = NOP_OP;
  end

  // Incoming bundle with the destination register resolved at capture time.
  always_comb begin
    in_bundle           = '0;
    in_bundle.rs        = i_rs;
    in_bundle.rt        = i_rt;
    in_bundle.rd        = i_rd;
    in_bundle.res       = i_res;
    in_bundle.ex        = i_ex;
    in_bundle.m         = i_m;
    in_bundle.wb        = i_wb;
    in_bundle.val_a     = i_valA;
    in_bundle.val_b     = i_valB;
    in_bundle.imm       = i_imm;
    in_bundle.pc_plus4  = i_pc_plus4;
    in_bundle.operation = i_operation;
    in_bundle.dst       = ((i_operation == ADDI_OP) || (i_operation == LW_OP)) ? i_rt : i_rd;
  end

  assign o_ready = !skid_valid_q;
  assign accept  = i_valid && o_ready;
  assign drain   = out_valid_q && i_ready;

  // Next-state for OUT and SKID.
  always_comb begin
    out_d        = out_q;
    out_valid_d  = out_valid_q;
    skid_d       = skid_q;
    skid_valid_d = skid_valid_q;

    if (i_flush) begin
      out_d        = bubble;
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
    end else if (!out_valid_q || drain) begin
      // OUT is free this cycle. A parked bundle has priority; accept cannot
      // happen while SKID is full because o_ready is low.
      if (skid_valid_q) begin
        out_d        = skid_q;
        out_valid_d  = 1'b1;
        skid_valid_d = 1'b0;
      end else if (accept) begin
        out_d       = in_bundle;
        out_valid_d = 1'b1;
      end else begin
        out_d       = bubble;
        out_valid_d = 1'b0;
      end
    end else if (accept) begin
      // OUT is stuck: park the new bundle.
      skid_d       = in_bundle;
      skid_valid_d = 1'b1;
    end
  end

  // Stall counter is intentionally not affected by flush.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (i_valid && !o_ready && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + STALL_CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_q        <= bubble;
      out_valid_q  <= 1'b0;
      skid_q       <= bubble;
      skid_valid_q <= 1'b0;
      stall_cnt_q  <= '0;
    end else begin
      out_q        <= out_d;
      out_valid_q  <= out_valid_d;
      skid_q       <= skid_d;
      skid_valid_q <= skid_valid_d;
      stall_cnt_q  <= stall_cnt_d;
    end
  end

  assign o_valid     = out_valid_q;
  assign o_rs        = out_q.rs;
  assign o_rt        = out_q.rt;
  assign o_rd        = out_q.rd;
  assign o_res       = out_q.res;
  assign o_ex        = out_q.ex;
  assign o_m         = out_q.m;
  assign o_wb        = out_q.wb;
  assign o_valA      = out_q.val_a;
  assign o_valB      = out_q.val_b;
  assign o_imm       = out_q.imm;
  assign o_pc_plus4  = out_q.pc_plus4;
  assign o_operation = out_q.operation;
  assign o_dst       = out_q.dst;
  assign o_stall_cnt = stall_cnt_q;

  // Load in the EX-bound slot whose destination is read by the ID bundle.
  // Register 0 is hard-wired, so it never creates a hazard.
  assign o_load_use = out_valid_q && (out_q.operation == LW_OP) && (out_q.dst != '0) &&
                      i_valid && ((i_rs == out_q.dst) || (i_rt == out_q.dst));

endmodule

// File: tb/tb_id_ex_skid_reg.sv
module tb_id_ex_skid_reg;

  logic        clk = 1'b0;
  logic        rst, i_valid, i_flush, i_ready;
  logic [4:0]  i_rs, i_rt, i_rd, i_res;
  logic [1:0]  i_ex, i_wb;
  logic [2:0]  i_m;
  logic [31:0] i_valA, i_valB, i_imm, i_pc_plus4;
  logic [5:0]  i_operation;

  logic        o_ready, o_valid, o_load_use;
  logic [4:0]  o_rs, o_rt, o_rd, o_res, o_dst;
  logic [1:0]  o_ex, o_wb;
  logic [2:0]  o_m;
  logic [31:0] o_valA, o_valB, o_imm, o_pc_plus4;
  logic [5:0]  o_operation;
  logic [15:0] o_stall_cnt;

  // Second instance with a 2-bit stall counter for the saturation check.
  logic        s_ready, s_valid, s_load_use;
  logic [4:0]  s_rs, s_rt, s_rd, s_res, s_dst;
  logic [1:0]  s_ex, s_wb;
  logic [2:0]  s_m;
  logic [31:0] s_valA, s_valB, s_imm, s_pc_plus4;
  logic [5:0]  s_operation;
  logic [1:0]  s_stall_cnt;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  id_ex_skid_reg dut (
    .clk(clk), .rst(rst), .i_valid(i_valid), .o_ready(o_ready), .i_flush(i_flush),
    .i_rs(i_rs), .i_rt(i_rt), .i_rd(i_rd), .i_res(i_res), .i_ex(i_ex), .i_m(i_m),
    .i_wb(i_wb), .i_valA(i_valA), .i_valB(i_valB), .i_imm(i_imm),
    .i_pc_plus4(i_pc_plus4), .i_operation(i_operation), .o_valid(o_valid),
    .i_ready(i_ready), .o_rs(o_rs), .o_rt(o_rt), .o_rd(o_rd), .o_res(o_res),
    .o_ex(o_ex), .o_m(o_m), .o_wb(o_wb), .o_valA(o_valA), .o_valB(o_valB),
    .o_imm(o_imm), .o_pc_plus4(o_pc_plus4), .o_operation(o_operation), .o_dst(o_dst),
    .o_load_use(o_load_use), .o_stall_cnt(o_stall_cnt)
  );

  id_ex_skid_reg #(.STALL_CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .i_valid(i_valid), .o_ready(s_ready), .i_flush(i_flush),
    .i_rs(i_rs), .i_rt(i_rt), .i_rd(i_rd), .i_res(i_res), .i_ex(i_ex), .i_m(i_m),
    .i_wb(i_wb), .i_valA(i_valA), .i_valB(i_valB), .i_imm(i_imm),
    .i_pc_plus4(i_pc_plus4), .i_operation(i_operation), .o_valid(s_valid),
    .i_ready(i_ready), .o_rs(s_rs), .o_rt(s_rt), .o_rd(s_rd), .o_res(s_res),
    .o_ex(s_ex), .o_m(s_m), .o_wb(s_wb), .o_valA(s_valA), .o_valB(s_valB),
    .o_imm(s_imm), .o_pc_plus4(s_pc_plus4), .o_operation(s_operation), .o_dst(s_dst),
    .o_load_use(s_load_use), .o_stall_cnt(s_stall_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive a bundle; the remaining fields are derived from val so they vary.
  task automatic drive(input logic v, input logic [5:0] op, input logic [4:0] rs,
                       input logic [4:0] rt, input logic [4:0] rd, input logic [31:0] val);
    i_valid     = v;
    i_operation = op;
    i_rs        = rs;
    i_rt        = rt;
    i_rd        = rd;
    i_res       = rs ^ rt;
    i_ex        = val[1:0];
    i_m         = val[2:0];
    i_wb        = 2'b11;
    i_valA      = val;
    i_valB      = ~val;
    i_imm       = val << 4;
    i_pc_plus4  = val + 32'd4;
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; i_flush = 1'b0; i_ready = 1'b1;
    drive(1'b0, 6'h00, 5'd0, 5'd0, 5'd0, 32'd0);
    step(); step();
    rst = 1'b0;

    // Reset state
    chk("rst_valid", {31'd0, o_valid}, 32'd0);
    chk("rst_ready", {31'd0, o_ready}, 32'd1);
    chk("rst_op", {26'd0, o_operation}, 32'h3f);
    chk("rst_valA", o_valA, 32'd0);
    chk("rst_cnt", {16'd0, o_stall_cnt}, 32'd0);
    chk("rst_dst", {27'd0, o_dst}, 32'd0);

    // addi: destination is rt, o_rd is passed through
    drive(1'b1, 6'b001000, 5'd1, 5'd5, 5'd9, 32'h55);
    step();
    chk("addi_valid", {31'd0, o_valid}, 32'd1);
    chk("addi_dst", {27'd0, o_dst}, 32'd5);
    chk("addi_rd", {27'd0, o_rd}, 32'd9);
    chk("addi_op", {26'd0, o_operation}, 32'h08);
    i_valid = 1'b0;
    step();
    chk("idle_valid", {31'd0, o_valid}, 32'd0);
    chk("idle_op", {26'd0, o_operation}, 32'h3f);
    chk("idle_valA", o_valA, 32'd0);

    // Streaming, R-type so dst = rd
    for (int k = 1; k <= 8; k++) begin
      drive(1'b1, 6'h00, 5'd2, 5'd3, 5'(k + 10), 32'(k));
      step();
      chk("stream_valA", o_valA, 32'(k));
      chk("stream_ready", {31'd0, o_ready}, 32'd1);
      chk("stream_dst", {27'd0, o_dst}, 32'(k + 10));
    end
    chk("stream_pc", o_pc_plus4, 32'd12);
    i_valid = 1'b0;
    step();
    chk("stream_end", {31'd0, o_valid}, 32'd0);

    // Back-pressure: A in OUT, B into SKID, C waits three cycles
    drive(1'b1, 6'h00, 5'd1, 5'd2, 5'd3, 32'hA);
    step();
    i_ready = 1'b0;
    drive(1'b1, 6'h00, 5'd1, 5'd2, 5'd3, 32'hB);
    step();
    chk("bp_outA", o_valA, 32'hA);
    chk("bp_ready0", {31'd0, o_ready}, 32'd0);
    drive(1'b1, 6'h00, 5'd1, 5'd2, 5'd3, 32'hC);
    step(); step(); step();
    chk("bp_cnt3", {16'd0, o_stall_cnt}, 32'd3);
    chk("bp_holdA", o_valA, 32'hA);
    i_ready = 1'b1;
    step();
    chk("bp_outB", o_valA, 32'hB);
    chk("bp_validB", {31'd0, o_valid}, 32'd1);
    chk("bp_ready1", {31'd0, o_ready}, 32'd1);
    step();
    chk("bp_outC", o_valA, 32'hC);
    i_valid = 1'b0;
    step();
    chk("bp_drained", {31'd0, o_valid}, 32'd0);
    chk("bp_cnt4", {16'd0, o_stall_cnt}, 32'd4);

    // Flush with OUT and SKID full and D incoming
    drive(1'b1, 6'h00, 5'd1, 5'd2, 5'd3, 32'h11);
    step();
    i_ready = 1'b0;
    drive(1'b1, 6'h00, 5'd1, 5'd2, 5'd3, 32'h12);
    step();
    chk("fl_skidfull", {31'd0, o_ready}, 32'd0);
    drive(1'b1, 6'h00, 5'd1, 5'd2, 5'd3, 32'h1D);
    i_flush = 1'b1;
    step();
    chk("fl_valid", {31'd0, o_valid}, 32'd0);
    chk("fl_ready", {31'd0, o_ready}, 32'd1);
    chk("fl_op", {26'd0, o_operation}, 32'h3f);
    chk("fl_wb", {30'd0, o_wb}, 32'd0);
    chk("fl_valA", o_valA, 32'd0);
    chk("fl_cnt", {16'd0, o_stall_cnt}, 32'd5);
    i_flush = 1'b0; i_valid = 1'b0; i_ready = 1'b1;
    step();
    chk("fl_noD", {31'd0, o_valid}, 32'd0);

    // Load-use
    i_ready = 1'b0;
    drive(1'b1, 6'b100011, 5'd1, 5'd7, 5'd2, 32'h40);
    step();
    chk("lu_dst", {27'd0, o_dst}, 32'd7);
    drive(1'b1, 6'h00, 5'd7, 5'd0, 5'd4, 32'h41);
    #1;
    chk("lu_rs", {31'd0, o_load_use}, 32'd1);
    drive(1'b1, 6'h00, 5'd3, 5'd7, 5'd4, 32'h41);
    #1;
    chk("lu_rt", {31'd0, o_load_use}, 32'd1);
    drive(1'b1, 6'h00, 5'd3, 5'd4, 5'd7, 32'h41);
    #1;
    chk("lu_nomatch", {31'd0, o_load_use}, 32'd0);
    drive(1'b0, 6'h00, 5'd7, 5'd7, 5'd4, 32'h41);
    #1;
    chk("lu_novalid", {31'd0, o_load_use}, 32'd0);
    i_flush = 1'b1;
    step();
    i_flush = 1'b0;
    drive(1'b1, 6'b100011, 5'd1, 5'd0, 5'd2, 32'h42);
    step();
    chk("lu0_dst", {27'd0, o_dst}, 32'd0);
    drive(1'b1, 6'h00, 5'd0, 5'd0, 5'd4, 32'h43);
    #1;
    chk("lu0_flag", {31'd0, o_load_use}, 32'd0);
    i_flush = 1'b1; i_valid = 1'b0;
    step();
    i_flush = 1'b0;

    // Reset while SKID is full
    i_ready = 1'b1;
    drive(1'b1, 6'h00, 5'd1, 5'd2, 5'd3, 32'hE);
    step();
    i_ready = 1'b0;
    drive(1'b1, 6'h00, 5'd1, 5'd2, 5'd3, 32'hF);
    step();
    chk("mr_skidfull", {31'd0, o_ready}, 32'd0);
    rst = 1'b1; i_valid = 1'b0;
    step();
    rst = 1'b0;
    chk("mr_valid", {31'd0, o_valid}, 32'd0);
    chk("mr_ready", {31'd0, o_ready}, 32'd1);
    chk("mr_op", {26'd0, o_operation}, 32'h3f);
    chk("mr_valA", o_valA, 32'd0);
    chk("mr_cnt", {16'd0, o_stall_cnt}, 32'd0);
    i_ready = 1'b1;
    step();
    chk("mr_noF", {31'd0, o_valid}, 32'd0);

    // Saturation: five stall cycles
    drive(1'b1, 6'h00, 5'd1, 5'd2, 5'd3, 32'h60);
    step();
    i_ready = 1'b0;
    drive(1'b1, 6'h00, 5'd1, 5'd2, 5'd3, 32'h61);
    step();
    drive(1'b1, 6'h00, 5'd1, 5'd2, 5'd3, 32'h62);
    for (int k = 0; k < 5; k++) step();
    chk("sat_wide", {16'd0, o_stall_cnt}, 32'd5);
    chk("sat_narrow", {30'd0, s_stall_cnt}, 32'd3);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
